// File: rtl/board_state_ctrl.sv
// Tic-tac-toe engine: keypad moves into a nine-cell board, turn order, win/draw detection and scores.
// Optional WIN_BLINK_EN: the winning line blinks while the game is over.
module board_state_ctrl #(
  parameter logic [3:0] RESTART_CODE = 4'hF,
  parameter int         BLINK_TICKS  = 25_000_000,
  parameter logic [3:0] SCORE_MAX    = 4'd9
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [1:0] a1,
  output logic [1:0] a2,
  output logic [1:0] a3,
  output logic [1:0] a4,
  output logic [1:0] a5,
  output logic [1:0] a6,
  output logic [1:0] a7,
  output logic [1:0] a8,
  output logic [1:0] a9,
  output logic       turn,
  output logic       game_over,
  output logic [1:0] winner,
  output logic [3:0] score_x,
  output logic [3:0] score_o,
  output logic       illegal_move
);

  typedef enum logic [1:0] {PLAY, CHECK, OVER} state_t;

  // Bit k of each mask is cell k+1: three rows, three columns, two diagonals.
  localparam logic [8:0] LINE_SET [8] = '{9'h007, 9'h038, 9'h1C0,
                                          9'h049, 9'h092, 9'h124,
                                          9'h111, 9'h054};

  state_t          state;
  logic [8:0][1:0] board;
  logic [8:0][1:0] disp;
  logic [3:0]      move_count;
  logic            starter;
  logic [1:0]      mover_sym;
  logic [8:0]      win_mask;
  logic            key_is_cell;
  logic            key_restart;
  logic [3:0]      cell_idx;
  logic            cell_empty;

  function automatic logic [8:0] line_mask(input logic [8:0][1:0] b, input logic [1:0] sym);
    logic [8:0] occ;
    logic [8:0] m;
    m = '0;
    for (int k = 0; k < 9; k++) occ[k] = (b[k] == sym);
    for (int l = 0; l < 8; l++)
      if ((LINE_SET[l] & occ) == LINE_SET[l]) m = m | LINE_SET[l];
    return m;
  endfunction

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= SCORE_MAX) ? s : s + 4'd1;
  endfunction

  assign mover_sym   = turn ? 2'b10 : 2'b01;
  assign win_mask    = line_mask(board, mover_sym);
  assign key_restart = (key_code == RESTART_CODE);
  assign key_is_cell = (key_code >= 4'd1) && (key_code <= 4'd9);
  assign cell_idx    = key_code - 4'd1;
  assign cell_empty  = key_is_cell && (board[cell_idx] == 2'b00);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= PLAY;
      board        <= '0;
      move_count   <= '0;
      starter      <= 1'b0;
      turn         <= 1'b0;
      game_over    <= 1'b0;
      winner       <= 2'b00;
      score_x      <= '0;
      score_o      <= '0;
      illegal_move <= 1'b0;
    end else begin
      illegal_move <= 1'b0;
      case (state)
        PLAY: if (key_valid) begin
          if (key_restart) begin
            board      <= '0;
            move_count <= '0;
            winner     <= 2'b00;
            game_over  <= 1'b0;
            turn       <= starter;
          end else if (cell_empty) begin
            board[cell_idx] <= mover_sym;
            move_count      <= move_count + 4'd1;
            state           <= CHECK;
          end else begin
            illegal_move <= 1'b1;
          end
        end
        // Keys arriving in this single cycle are dropped on purpose.
        CHECK: begin
          if (|win_mask) begin
            state     <= OVER;
            game_over <= 1'b1;
            winner    <= mover_sym;
            if (turn) score_o <= sat_inc(score_o);
            else      score_x <= sat_inc(score_x);
          end else if (move_count == 4'd9) begin
            state     <= OVER;
            game_over <= 1'b1;
            winner    <= 2'b00;
          end else begin
            turn  <= ~turn;
            state <= PLAY;
          end
        end
        OVER: if (key_valid) begin
          if (key_restart) begin
            board      <= '0;
            move_count <= '0;
            winner     <= 2'b00;
            game_over  <= 1'b0;
            starter    <= ~starter;
            turn       <= ~starter;
            state      <= PLAY;
          end else begin
            illegal_move <= 1'b1;
          end
        end
        default: state <= PLAY;
      endcase
    end
  end

`ifdef WIN_BLINK_EN
  localparam int CNT_W = (BLINK_TICKS > 1) ? $clog2(BLINK_TICKS) : 1;

  logic [CNT_W-1:0] blink_cnt;
  logic             blink_off;
  logic [8:0]       blink_mask;

  // Mask is latched from the CHECK cycle so both lines of a double win blink.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      blink_cnt  <= '0;
      blink_off  <= 1'b0;
      blink_mask <= '0;
    end else if (state == CHECK) begin
      blink_cnt  <= '0;
      blink_off  <= 1'b0;
      blink_mask <= win_mask;
    end else if (state == OVER) begin
      if (key_valid && key_restart) begin
        blink_cnt  <= '0;
        blink_off  <= 1'b0;
        blink_mask <= '0;
      end else if (blink_cnt == CNT_W'(BLINK_TICKS - 1)) begin
        blink_cnt <= '0;
        blink_off <= ~blink_off;
      end else begin
        blink_cnt <= blink_cnt + 1'b1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 9; k++)
      disp[k] = (blink_off && blink_mask[k]) ? 2'b00 : board[k];
  end
`else
  assign disp = board;
`endif

  assign a1 = disp[0];
  assign a2 = disp[1];
  assign a3 = disp[2];
  assign a4 = disp[3];
  assign a5 = disp[4];
  assign a6 = disp[5];
  assign a7 = disp[6];
  assign a8 = disp[7];
  assign a9 = disp[8];

endmodule

// File: tb/tb_board_state_ctrl.sv
// Bench for board_state_ctrl: game-rule model checked every cycle plus directed literal checks.
module tb_board_state_ctrl;

  localparam logic [3:0] RST_CODE = 4'hF;
  localparam int         BT       = 4;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       key_valid = 1'b0;
  logic [3:0] key_code = 4'd0;
  logic [1:0] a1, a2, a3, a4, a5, a6, a7, a8, a9;
  logic       turn, game_over, illegal_move;
  logic [1:0] winner;
  logic [3:0] score_x, score_o;

  board_state_ctrl #(.RESTART_CODE(RST_CODE), .BLINK_TICKS(BT), .SCORE_MAX(4'd9)) dut (
    .clock(clock), .reset(reset), .key_valid(key_valid), .key_code(key_code),
    .a1(a1), .a2(a2), .a3(a3), .a4(a4), .a5(a5), .a6(a6), .a7(a7), .a8(a8), .a9(a9),
    .turn(turn), .game_over(game_over), .winner(winner),
    .score_x(score_x), .score_o(score_o), .illegal_move(illegal_move)
  );

  always #5 clock = ~clock;

  logic [1:0] cells [9];
  always_comb begin
    cells[0] = a1; cells[1] = a2; cells[2] = a3;
    cells[3] = a4; cells[4] = a5; cells[5] = a6;
    cells[6] = a7; cells[7] = a8; cells[8] = a9;
  end

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 0;
  bit last_ill = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Game-level model: board contents, whose move, outcome one cycle after a placement.
  int         lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                               '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};
  logic [1:0] m_board [9] = '{default: 2'b00};
  bit         m_turn = 0, m_starter = 0, m_over = 0, m_pending = 0, m_ill = 0;
  logic [1:0] m_winner = 2'b00;
  int         m_sx = 0, m_so = 0, m_ovcyc = 0;
  bit         was_over;
  logic [1:0] sym;

  function automatic bit has_line(input logic [1:0] s);
    for (int l = 0; l < 8; l++)
      if (m_board[lines[l][0]] == s && m_board[lines[l][1]] == s && m_board[lines[l][2]] == s)
        return 1;
    return 0;
  endfunction

  function automatic bit on_win_line(input int k);
    for (int l = 0; l < 8; l++)
      if ((lines[l][0] == k || lines[l][1] == k || lines[l][2] == k) &&
          m_board[lines[l][0]] == m_winner && m_board[lines[l][1]] == m_winner &&
          m_board[lines[l][2]] == m_winner)
        return 1;
    return 0;
  endfunction

  function automatic int filled();
    int n = 0;
    for (int k = 0; k < 9; k++) if (m_board[k] != 2'b00) n++;
    return n;
  endfunction

  function automatic int exp_cell(input int k);
`ifdef WIN_BLINK_EN
    if (m_over && m_winner != 2'b00 && ((m_ovcyc / BT) % 2 == 1) && on_win_line(k)) return 0;
`endif
    return int'(m_board[k]);
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int k = 0; k < 9; k++) m_board[k] = 2'b00;
      m_turn = 0; m_starter = 0; m_over = 0; m_pending = 0; m_ill = 0;
      m_winner = 2'b00; m_sx = 0; m_so = 0; m_ovcyc = 0;
    end else begin
      was_over = m_over;
      m_ill = 0;
      if (m_pending) begin
        m_pending = 0;
        sym = m_turn ? 2'b10 : 2'b01;
        if (has_line(sym)) begin
          m_over = 1; m_winner = sym;
          if (m_turn) m_so = (m_so < 9) ? m_so + 1 : m_so;
          else        m_sx = (m_sx < 9) ? m_sx + 1 : m_sx;
        end else if (filled() == 9) begin
          m_over = 1; m_winner = 2'b00;
        end else begin
          m_turn = !m_turn;
        end
      end else if (key_valid) begin
        if (key_code == RST_CODE) begin
          if (m_over) m_starter = !m_starter;
          for (int k = 0; k < 9; k++) m_board[k] = 2'b00;
          m_over = 0; m_winner = 2'b00; m_turn = m_starter;
        end else if (!m_over && key_code >= 1 && key_code <= 9 && m_board[key_code - 1] == 2'b00) begin
          m_board[key_code - 1] = m_turn ? 2'b10 : 2'b01;
          m_pending = 1;
        end else begin
          m_ill = 1;
        end
      end
      if (m_over && was_over) m_ovcyc++;
      else m_ovcyc = 0;
    end
  end

  always @(negedge clock) begin
    if (reset && cmp_en) begin
      for (int k = 0; k < 9; k++) chk($sformatf("cell_a%0d", k + 1), int'(cells[k]), exp_cell(k));
      chk("turn", int'(turn), int'(m_turn));
      chk("game_over", int'(game_over), int'(m_over));
      chk("winner", int'(winner), int'(m_winner));
      chk("score_x", int'(score_x), m_sx);
      chk("score_o", int'(score_o), m_so);
      chk("illegal_move", int'(illegal_move), int'(m_ill));
    end
  end

  // All tasks start and end 1 time unit after a rising edge.
  task automatic press(input logic [3:0] c);
    key_valid = 1'b1; key_code = c;
    @(posedge clock); #1;
    key_valid = 1'b0;
    last_ill = illegal_move;
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
  endtask

  int xseq [5] = '{1, 4, 2, 5, 3};
  int oseq [6] = '{1, 4, 2, 5, 9, 6};
  int draw [9] = '{1, 2, 3, 5, 4, 6, 8, 7, 9};

  initial begin
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
    cmp_en = 1;
    chk("rst_turn", int'(turn), 0);
    chk("rst_game_over", int'(game_over), 0);
    chk("rst_score_x", int'(score_x), 0);
    chk("rst_a5", int'(a5), 0);

    // X wins on the top row.
    foreach (xseq[i]) press(4'(xseq[i]));
    chk("t1_a1", int'(a1), 1);
    chk("t1_a3", int'(a3), 1);
    chk("t1_a4", int'(a4), 2);
    chk("t1_game_over", int'(game_over), 1);
    chk("t1_winner", int'(winner), 1);
    chk("t1_score_x", int'(score_x), 1);
`ifdef WIN_BLINK_EN
    repeat (BT) @(posedge clock);
    #1;
    chk("blink_a1_off", int'(a1), 0);
    chk("blink_a4_steady", int'(a4), 2);
`endif

    // Occupied cell.
    do_reset();
    press(4'd5);
    press(4'd5);
    chk("t2_illegal", int'(last_ill), 1);
    chk("t2_a5", int'(a5), 1);
    chk("t2_turn", int'(turn), 1);

    // Draw, then restart hands first move to O.
    do_reset();
    foreach (draw[i]) press(4'(draw[i]));
    chk("t3_game_over", int'(game_over), 1);
    chk("t3_winner", int'(winner), 0);
    chk("t3_score_x", int'(score_x), 0);
    chk("t3_score_o", int'(score_o), 0);
    press(RST_CODE);
    chk("t3_turn", int'(turn), 1);
    chk("t3_a1", int'(a1), 0);
    chk("t3_game_over_clr", int'(game_over), 0);

    // Key during the CHECK cycle is dropped; illegal code; restart mid-game.
    do_reset();
    key_valid = 1'b1; key_code = 4'd1;
    @(posedge clock); #1;
    key_code = 4'd9;
    @(posedge clock); #1;
    key_valid = 1'b0;
    chk("t4_a9", int'(a9), 0);
    chk("t4_no_illegal", int'(illegal_move), 0);
    chk("t4_turn", int'(turn), 1);
    press(4'd0);
    chk("t4_code0_illegal", int'(last_ill), 1);
    press(RST_CODE);
    chk("t4_restart_turn", int'(turn), 0);
    chk("t4_restart_a1", int'(a1), 0);

    // Eleven X wins with alternating starters.
    do_reset();
    for (int g = 0; g < 11; g++) begin
      if (g % 2 == 0) foreach (xseq[i]) press(4'(xseq[i]));
      else            foreach (oseq[i]) press(4'(oseq[i]));
      if (g == 8) chk("t5_score9", int'(score_x), 9);
      if (g == 10) begin
        chk("t5_sat_score", int'(score_x), 9);
        chk("t5_game_over", int'(game_over), 1);
        chk("t5_winner", int'(winner), 1);
        chk("t5_score_o", int'(score_o), 0);
      end
      press(RST_CODE);
    end

    // Reset lands while the winning move is in CHECK.
    foreach (xseq[i]) if (i < 4) press(4'(xseq[i]));
    key_valid = 1'b1; key_code = 4'd3;
    @(posedge clock); #1;
    key_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk("t6_a1", int'(a1), 0);
    chk("t6_a3", int'(a3), 0);
    chk("t6_turn", int'(turn), 0);
    chk("t6_game_over", int'(game_over), 0);
    chk("t6_winner", int'(winner), 0);
    chk("t6_score_x", int'(score_x), 0);
    chk("t6_score_o", int'(score_o), 0);
    @(posedge clock); #1;
    reset = 1'b1;
    repeat (4) @(posedge clock);
    #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
